gate_sweep_checker: RTL and testbench

Hardware successor to the team's per-gate exhaustive truth-table benches. It drives every input combination of an N-input combinational gate under test and waits a programmable settle time before sampling the gate's output. Each sample is compared with a selectable reference function, and the block reports the failure count and the first failing vector. It sits beside any gate block on the lab boards, so gate-level self-test runs on silicon/FPGA without a simulator.

---
 rtl/gate_sweep_checker.sv | 135 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
// Exhaustively sweeps every input vector of an N_IN-input combinational gate.
// Each vector is held for SETTLE cycles, then the gate output is sampled and
// compared with a selectable reference function. The block reports the
// mismatch count, the first failing vector and a pass flag.
module gate_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mode,
    input  logic            dut_y,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic [N_IN-1:0] first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } state_t;

    // Settle counter only needs to reach SETTLE-1.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
    localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
    localparam logic [N_IN:0]   FC_ONE      = (N_IN + 1)'(1);

    state_t          state;
    logic [2:0]      mode_q;
    logic [N_IN-1:0] vec;
    logic [CW-1:0]   settle_cnt;
    logic            exp_y;
    logic            mismatch;

    // Reference function selected by the latched mode.
    function automatic logic ref_fn(input logic [2:0] m, input logic [N_IN-1:0] v);
        logic r;
        r = 1'b0;
        case (m)
            3'd0:    r = &v;
            3'd1:    r = |v;
            3'd2:    r = ^v;
            3'd3:    r = ~&v;
            3'd4:    r = ~|v;
            3'd5:    r = ~^v;
            3'd6:    r = v[0];
            default: r = ~v[0];
        endcase
        return r;
    endfunction

    // Expected gate output for the vector currently applied, and the compare.
    always_comb begin
        exp_y    = ref_fn(mode_q, vec);
        mismatch = dut_y ^ exp_y;
    end

    // Sweep sequencer with registered outputs; mismatch only feeds registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mode_q         <= '0;
            vec            <= '0;
            settle_cnt     <= '0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    stim <= '0;
                    if (start) begin
                        mode_q         <= mode;
                        fail_count     <= '0;
                        first_fail_vec <= '0;
                        pass           <= 1'b0;
                        vec            <= '0;
                        settle_cnt     <= '0;
                        busy           <= 1'b1;
                        state          <= APPLY;
                    end
                end
                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_ONE;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_count <= fail_count + FC_ONE;
                        if (fail_count == '0) begin
                            first_fail_vec <= vec;
                        end
                    end
                    if (vec == '1) begin
                        // pass uses the count including this final compare.
                        pass  <= (fail_count == '0) && !mismatch;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        stim  <= '0;
                        state <= DONE;
                    end else begin
                        vec        <= vec + VEC_ONE;
                        stim       <= vec + VEC_ONE;
                        settle_cnt <= '0;
                        state      <= APPLY;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (N_IN/SETTLE = 2/2, 3/1, 1/1)
// each driving a configurable behavioural gate. Directed table entries plus
// randomized sweeps checked against a vector-by-vector reference model.
module tb_gate_sweep_checker;

    localparam int NI[3] = '{2, 3, 1};
    localparam int SI[3] = '{2, 1, 1};

    logic clk = 1'b0;
    logic rst;

    logic [2:0]      start_v;
    logic [2:0][2:0] mode_v;
    logic [2:0]      y_v;
    logic [2:0]      busy_v, done_v, pass_v;

    logic [1:0] stim0, ffv0;
    logic [2:0] stim1, ffv1, fc0;
    logic [0:0] stim2, ffv2;
    logic [3:0] fc1;
    logic [1:0] fc2;

    logic [2:0][7:0] stim_w, ffv_w;
    logic [2:0][8:0] fc_w;

    int          gate_v[3];
    logic [255:0] tt_v[3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gate_sweep_checker #(.N_IN(2), .SETTLE(2)) u_d0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]), .dut_y(y_v[0]),
        .stim(stim0), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .fail_count(fc0), .first_fail_vec(ffv0)
    );
    gate_sweep_checker #(.N_IN(3), .SETTLE(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]), .dut_y(y_v[1]),
        .stim(stim1), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .fail_count(fc1), .first_fail_vec(ffv1)
    );
    gate_sweep_checker #(.N_IN(1), .SETTLE(1)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_v[2]), .dut_y(y_v[2]),
        .stim(stim2), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .fail_count(fc2), .first_fail_vec(ffv2)
    );

    assign stim_w[0] = 8'(stim0);
    assign stim_w[1] = 8'(stim1);
    assign stim_w[2] = 8'(stim2);
    assign ffv_w[0]  = 8'(ffv0);
    assign ffv_w[1]  = 8'(ffv1);
    assign ffv_w[2]  = 8'(ffv2);
    assign fc_w[0]   = 9'(fc0);
    assign fc_w[1]   = 9'(fc1);
    assign fc_w[2]   = 9'(fc2);

    // Behavioural gates: 0 OR, 1 stuck-at-0, 2 XOR, 3 NAND, 4 NOT(bit0), 5 truth table
    function automatic logic gate_out(input int g, input logic [255:0] tt, input int v, input int n);
        int all_ones;
        all_ones = (1 << n) - 1;
        case (g)
            0:       return v != 0;
            1:       return 1'b0;
            2:       return ($countones(v) % 2) == 1;
            3:       return v != all_ones;
            4:       return (v % 2) == 0;
            default: return tt[v];
        endcase
    endfunction

    // Reference functions expressed arithmetically on the vector value.
    function automatic logic ref_model(input int m, input int v, input int n);
        int all_ones;
        int ones;
        all_ones = (1 << n) - 1;
        ones     = $countones(v);
        case (m)
            0:       return v == all_ones;
            1:       return v != 0;
            2:       return (ones % 2) == 1;
            3:       return v != all_ones;
            4:       return v == 0;
            5:       return (ones % 2) == 0;
            6:       return (v % 2) == 1;
            default: return (v % 2) == 0;
        endcase
    endfunction

    function automatic void model_sweep(input int n, input int m, input int g, input logic [255:0] tt,
                                        output int fails, output int first);
        fails = 0;
        first = 0;
        for (int v = 0; v < (1 << n); v++) begin
            if (gate_out(g, tt, v, n) != ref_model(m, v, n)) begin
                if (fails == 0) first = v;
                fails++;
            end
        end
    endfunction

    always_comb begin
        y_v = '0;
        for (int i = 0; i < 3; i++) begin
            y_v[i] = gate_out(gate_v[i], tt_v[i], int'(stim_w[i]), NI[i]);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Runs one sweep on instance i. Cycle 1 is the cycle right after the edge
    // that samples start; done must appear in cycle 2^N*(SETTLE+1)+1.
    task automatic run_sweep(input int i, input int g, input int m, input logic [255:0] tt,
                             input bit perturb, input int exp_fail, input int exp_first,
                             input bit exp_pass);
        int s, total, budget, cyc, bad;
        bit found;
        s      = SI[i];
        total  = (1 << NI[i]) * (s + 1);
        budget = total + 10;
        gate_v[i]  = g;
        tt_v[i]    = tt;
        mode_v[i]  = 3'(m);
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        cyc   = 1;
        bad   = 0;
        found = 1'b0;
        while (1) begin
            if (done_v[i] === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (busy_v[i] !== 1'b1 || int'(stim_w[i]) != (cyc - 1) / (s + 1)) bad++;
            if (perturb && cyc == 3) begin
                start_v[i] = 1'b1;
                mode_v[i]  = mode_v[i] ^ 3'b111;
            end
            if (perturb && cyc == 4) start_v[i] = 1'b0;
            if (cyc >= budget) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        start_v[i] = 1'b0;
        chk("stim_seq_bad_cycles", bad, 0);
        chk("done_cycle", found ? cyc : -1, total + 1);
        chk("fail_count", int'(fc_w[i]), exp_fail);
        if (exp_fail != 0) chk("first_fail_vec", int'(ffv_w[i]), exp_first);
        chk("pass", int'(pass_v[i]), int'(exp_pass));
        chk("busy_in_done", int'(busy_v[i]), 0);
        chk("stim_in_done", int'(stim_w[i]), 0);
        // start during DONE must be ignored
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        chk("start_in_done_ignored", int'(busy_v[i]), 0);
        chk("done_one_cycle", int'(done_v[i]), 0);
        chk("pass_held", int'(pass_v[i]), int'(exp_pass));
    endtask

    typedef struct {
        int inst;
        int gate;
        int mode;
        bit perturb;
        int exp_fail;
        int exp_first;
        bit exp_pass;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] tt;
        int ef, efirst, cnt, cyc;

        tbl[0] = '{0, 0, 1, 1'b0, 0, 0, 1'b1};  // OR gate, OR ref
        tbl[1] = '{0, 1, 1, 1'b0, 3, 1, 1'b0};  // stuck-at-0 vs OR
        tbl[2] = '{0, 2, 1, 1'b0, 1, 3, 1'b0};  // XOR gate vs OR
        tbl[3] = '{1, 3, 3, 1'b0, 0, 0, 1'b1};  // NAND gate, NAND ref
        tbl[4] = '{1, 3, 0, 1'b0, 8, 0, 1'b0};  // NAND vs AND: every vector fails
        tbl[5] = '{0, 0, 1, 1'b1, 0, 0, 1'b1};  // restart + mode change mid-sweep
        tbl[6] = '{2, 1, 7, 1'b0, 1, 0, 1'b0};  // stuck-at-0 vs NOT
        tbl[7] = '{2, 4, 7, 1'b0, 0, 0, 1'b1};  // NOT gate, NOT ref, fresh counts
        tbl[8] = '{2, 4, 7, 1'b0, 0, 0, 1'b1};

        rst     = 1'b1;
        start_v = '0;
        mode_v  = '0;
        for (int i = 0; i < 3; i++) begin
            gate_v[i] = 0;
            tt_v[i]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_stim", int'(stim_w[i]), 0);
            chk("rst_busy", int'(busy_v[i]), 0);
            chk("rst_done", int'(done_v[i]), 0);
            chk("rst_pass", int'(pass_v[i]), 0);
            chk("rst_fail_count", int'(fc_w[i]), 0);
            chk("rst_first_fail_vec", int'(ffv_w[i]), 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 9; k++) begin
            run_sweep(tbl[k].inst, tbl[k].gate, tbl[k].mode, '0, tbl[k].perturb,
                      tbl[k].exp_fail, tbl[k].exp_first, tbl[k].exp_pass);
        end

        // Reset during APPLY of vector 2 on the 2-input instance.
        gate_v[0]  = 0;
        mode_v[0]  = 3'd1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (cyc = 1; cyc < 7; cyc++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_stim", int'(stim_w[0]), 2);
        chk("pre_rst_busy", int'(busy_v[0]), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_stim", int'(stim_w[0]), 0);
        chk("mid_rst_busy", int'(busy_v[0]), 0);
        chk("mid_rst_done", int'(done_v[0]), 0);
        chk("mid_rst_pass", int'(pass_v[0]), 0);
        chk("mid_rst_fail_count", int'(fc_w[0]), 0);
        chk("mid_rst_first_fail_vec", int'(ffv_w[0]), 0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) cnt++;
        end
        chk("no_activity_after_rst", cnt, 0);

        // Randomized sweeps against the reference model.
        for (int r = 0; r < 24; r++) begin
            int i, m, g;
            bit p;
            i = $urandom_range(0, 2);
            m = $urandom_range(0, 7);
            g = $urandom_range(0, 5);
            p = 1'($urandom_range(0, 1));
            for (int w = 0; w < 8; w++) tt[w*32 +: 32] = $urandom();
            model_sweep(NI[i], m, g, tt, ef, efirst);
            run_sweep(i, g, m, tt, p, ef, efirst, ef == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
